// File: rtl/attack_hit_ctrl.sv
// Attacker-side attack sequencer: windup/active/cooldown FSM, hitbox-vs-victim test,
// damage accumulation and knockback magnitude with a fixed-length hit pulse.
module attack_hit_ctrl #(
  parameter logic [7:0]  ATTACK_KEY      = 8'h2C,
  parameter logic [7:0]  LEFT_KEY        = 8'h50,
  parameter logic [7:0]  RIGHT_KEY       = 8'h4F,
  parameter int unsigned WINDUP_FRAMES   = 4,
  parameter int unsigned ACTIVE_FRAMES   = 3,
  parameter int unsigned COOLDOWN_FRAMES = 20,
  parameter int unsigned HIT_HOLD        = 8,
  parameter int unsigned REACH           = 20,
  parameter int unsigned DMG_PER_HIT     = 10,
  parameter int unsigned DMG_MAX         = 999,
  parameter int unsigned KB_BASE         = 96,
  parameter int unsigned KB_SHIFT        = 2
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [7:0]  keycode_1,
  input  logic [7:0]  keycode_2,
  input  logic [7:0]  keycode_3,
  input  logic [7:0]  keycode_4,
  input  logic [9:0]  AttX,
  input  logic [9:0]  AttY,
  input  logic [9:0]  AttW,
  input  logic [9:0]  AttH,
  input  logic [9:0]  VicX,
  input  logic [9:0]  VicY,
  input  logic [9:0]  VicW,
  input  logic [9:0]  VicH,
  input  logic        vic_death,
  output logic        hit,
  output logic [12:0] launch_dist,
  output logic [9:0]  damage,
  output logic        attack_active,
  output logic        facing
);

  localparam int unsigned MaxWA = (WINDUP_FRAMES > ACTIVE_FRAMES) ? WINDUP_FRAMES : ACTIVE_FRAMES;
  localparam int unsigned MaxFrames = (MaxWA > COOLDOWN_FRAMES) ? MaxWA : COOLDOWN_FRAMES;
  localparam int unsigned CntW  = $clog2(MaxFrames + 1);
  localparam int unsigned HoldW = $clog2(HIT_HOLD + 1);

  localparam logic [CntW-1:0]  WindupLast   = CntW'(WINDUP_FRAMES - 1);
  localparam logic [CntW-1:0]  ActiveLast   = CntW'(ACTIVE_FRAMES - 1);
  localparam logic [CntW-1:0]  CooldownLast = CntW'(COOLDOWN_FRAMES - 1);
  localparam logic [HoldW-1:0] HoldLoad     = HoldW'(HIT_HOLD);
  localparam logic [10:0]      Reach11      = 11'(REACH);
  localparam logic [10:0]      DmgStep      = 11'(DMG_PER_HIT);
  localparam logic [10:0]      DmgMax11     = 11'(DMG_MAX);
  localparam logic [13:0]      KbBase       = 14'(KB_BASE);
  localparam logic [13:0]      KbLimit      = 14'h0FFF;

  typedef enum logic [1:0] {
    StIdle,
    StWindup,
    StActive,
    StCooldown
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              connected_q, connected_d;
  logic              attack_key_q;
  logic              facing_q, facing_d;
  logic [9:0]        damage_q, damage_d;
  logic [12:0]       launch_q, launch_d;

  // ---------------------------------------------------------------------------
  // Key decoding
  // ---------------------------------------------------------------------------
  function automatic logic key_down(input logic [7:0] key);
    return (keycode_1 == key) || (keycode_2 == key) ||
           (keycode_3 == key) || (keycode_4 == key);
  endfunction

  logic attack_pressed, left_pressed, right_pressed, attack_edge;

  always_comb begin
    attack_pressed = key_down(ATTACK_KEY);
    left_pressed   = key_down(LEFT_KEY);
    right_pressed  = key_down(RIGHT_KEY);
    attack_edge    = attack_pressed && !attack_key_q;
  end

  always_comb begin
    facing_d = facing_q;
    if (left_pressed) begin
      facing_d = 1'b0;
    end else if (right_pressed) begin
      facing_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Hitbox overlap, all in 11 bits so sums of 10-bit coordinates never wrap
  // ---------------------------------------------------------------------------
  logic [10:0] att_x, att_y, att_w, att_h;
  logic [10:0] vic_x_lo, vic_x_hi, vic_y_lo, vic_y_hi;
  logic [10:0] att_right;
  logic [10:0] box_x_lo, box_x_hi, box_y_lo, box_y_hi;
  logic        x_overlap, y_overlap, overlap;

  always_comb begin
    att_x     = {1'b0, AttX};
    att_y     = {1'b0, AttY};
    att_w     = {1'b0, AttW};
    att_h     = {1'b0, AttH};
    vic_x_lo  = {1'b0, VicX};
    vic_x_hi  = {1'b0, VicX} + {1'b0, VicW};
    vic_y_lo  = {1'b0, VicY};
    vic_y_hi  = {1'b0, VicY} + {1'b0, VicH};
    att_right = att_x + att_w;

    if (facing_q) begin
      box_x_lo = att_right;
      box_x_hi = att_right + Reach11;
    end else begin
      // Clamp at the screen's left edge instead of wrapping.
      box_x_lo = (att_x >= Reach11) ? (att_x - Reach11) : 11'd0;
      box_x_hi = att_x;
    end
    box_y_lo = att_y;
    box_y_hi = att_y + att_h;

    // Half-open intervals: touching edges do not count.
    x_overlap = (box_x_lo < vic_x_hi) && (vic_x_lo < box_x_hi);
    y_overlap = (box_y_lo < vic_y_hi) && (vic_y_lo < box_y_hi);
    overlap   = x_overlap && y_overlap;
  end

  // ---------------------------------------------------------------------------
  // Damage and knockback for the next connect
  // ---------------------------------------------------------------------------
  logic [10:0] dmg_sum;
  logic [9:0]  damage_new;
  logic [13:0] kb_sum;
  logic [12:0] launch_new;

  always_comb begin
    dmg_sum    = {1'b0, damage_q} + DmgStep;
    damage_new = (dmg_sum > DmgMax11) ? DmgMax11[9:0] : dmg_sum[9:0];
    kb_sum     = KbBase + (14'(damage_new) << KB_SHIFT);
    launch_new = (kb_sum > KbLimit) ? KbLimit[12:0] : kb_sum[12:0];
  end

  // ---------------------------------------------------------------------------
  // Attack FSM
  // ---------------------------------------------------------------------------
  logic connect;

  assign connect = (state_q == StActive) && overlap && !connected_q && !vic_death;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    connected_d = connected_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (attack_edge) begin
          state_d     = StWindup;
          connected_d = 1'b0;
        end
      end
      StWindup: begin
        if (cnt_q == WindupLast) begin
          state_d = StActive;
          cnt_d   = '0;
        end
      end
      StActive: begin
        if (cnt_q == ActiveLast) begin
          state_d = StCooldown;
          cnt_d   = '0;
        end
      end
      StCooldown: begin
        if (cnt_q == CooldownLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (connect) begin
      connected_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Hit hold, damage and launch distance; victim death overrides a connect
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_d   = (hold_q != '0) ? (hold_q - 1'b1) : hold_q;
    damage_d = damage_q;
    launch_d = launch_q;

    if (vic_death) begin
      hold_d   = '0;
      damage_d = '0;
      launch_d = '0;
    end else if (connect) begin
      hold_d   = HoldLoad;
      damage_d = damage_new;
      launch_d = launch_new;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hold_q       <= '0;
      connected_q  <= 1'b0;
      attack_key_q <= 1'b0;
      facing_q     <= 1'b1;
      damage_q     <= '0;
      launch_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      connected_q  <= connected_d;
      attack_key_q <= attack_pressed;
      facing_q     <= facing_d;
      damage_q     <= damage_d;
      launch_q     <= launch_d;
    end
  end

  assign hit           = (hold_q != '0);
  assign launch_dist   = launch_q;
  assign damage        = damage_q;
  assign attack_active = (state_q == StWindup) || (state_q == StActive);
  assign facing        = facing_q;

endmodule

// File: tb/tb_attack_hit_ctrl.sv
// Directed self-checking bench for attack_hit_ctrl.
module tb_attack_hit_ctrl;

  localparam logic [7:0] AttackKey = 8'h2C;
  localparam logic [7:0] LeftKey   = 8'h50;
  localparam logic [7:0] RightKey  = 8'h4F;

  logic        frame_clk;
  logic        Reset_n;
  logic [7:0]  keycode_1, keycode_2, keycode_3, keycode_4;
  logic [9:0]  AttX, AttY, AttW, AttH;
  logic [9:0]  VicX, VicY, VicW, VicH;
  logic        vic_death;
  logic        hit;
  logic [12:0] launch_dist;
  logic [9:0]  damage;
  logic        attack_active;
  logic        facing;

  int tests;
  int fails;

  attack_hit_ctrl dut (
    .frame_clk     (frame_clk),
    .Reset_n       (Reset_n),
    .keycode_1     (keycode_1),
    .keycode_2     (keycode_2),
    .keycode_3     (keycode_3),
    .keycode_4     (keycode_4),
    .AttX          (AttX),
    .AttY          (AttY),
    .AttW          (AttW),
    .AttH          (AttH),
    .VicX          (VicX),
    .VicY          (VicY),
    .VicW          (VicW),
    .VicH          (VicH),
    .vic_death     (vic_death),
    .hit           (hit),
    .launch_dist   (launch_dist),
    .damage        (damage),
    .attack_active (attack_active),
    .facing        (facing)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
  endtask

  // One full attack from IDLE back to IDLE: 28 edges, sampled after each.
  task automatic run_attack(output int act_frames, output int hit_frames, output int first_hit);
    act_frames = 0;
    hit_frames = 0;
    first_hit  = -1;
    keycode_1  = AttackKey;
    for (int k = 0; k < 28; k++) begin
      step();
      if (k == 0) keycode_1 = 8'h00;
      if (attack_active) act_frames++;
      if (hit) begin
        hit_frames++;
        if (first_hit < 0) first_hit = k;
      end
    end
  endtask

  task automatic test_reset();
    keycode_1 = 8'h00; keycode_2 = 8'h00; keycode_3 = 8'h00; keycode_4 = 8'h00;
    AttX = 10'd100; AttY = 10'd230; AttW = 10'd60; AttH = 10'd60;
    VicX = 10'd170; VicY = 10'd230; VicW = 10'd60; VicH = 10'd60;
    vic_death = 1'b0;
    do_reset();
    tests++;
    if ({hit, launch_dist, damage, attack_active, facing} !== {1'b0, 13'd0, 10'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset: hit=%b launch=%0d dmg=%0d act=%b facing=%b, expected 0 0 0 0 1",
               hit, launch_dist, damage, attack_active, facing);
    end
  endtask

  task automatic test_basic_connect();
    int act, hits, first;
    do_reset();
    run_attack(act, hits, first);
    tests++;
    if (act !== 7) begin fails++; $display("FAIL basic_active_frames: got %0d expected 7", act); end
    tests++;
    if (first !== 5) begin fails++; $display("FAIL basic_first_hit: got %0d expected 5", first); end
    tests++;
    if (hits !== 8) begin fails++; $display("FAIL basic_hit_frames: got %0d expected 8", hits); end
    tests++;
    if (damage !== 10'd10) begin fails++; $display("FAIL basic_damage: got %0d expected 10", damage); end
    tests++;
    if (launch_dist !== 13'd136) begin
      fails++; $display("FAIL basic_launch: got %0d expected 136", launch_dist);
    end
    // Back in IDLE: a fresh press (victim far away) starts a new windup immediately.
    VicX = 10'd400;
    keycode_1 = AttackKey;
    step();
    keycode_1 = 8'h00;
    tests++;
    if (attack_active !== 1'b1) begin
      fails++; $display("FAIL basic_idle_after_cooldown: act=%b expected 1", attack_active);
    end
    for (int k = 0; k < 27; k++) step();
    tests++;
    if (damage !== 10'd10 || hit !== 1'b0) begin
      fails++; $display("FAIL basic_miss_far: dmg=%0d hit=%b expected 10 0", damage, hit);
    end
    VicX = 10'd170;
  endtask

  task automatic test_boundary();
    int act, hits, first;
    do_reset();
    VicX = 10'd180;
    run_attack(act, hits, first);
    tests++;
    if (hits !== 0 || damage !== 10'd0) begin
      fails++; $display("FAIL edge_right_touch: hits=%0d dmg=%0d expected 0 0", hits, damage);
    end
    keycode_3 = LeftKey; keycode_4 = RightKey;
    step();
    tests++;
    if (facing !== 1'b0) begin fails++; $display("FAIL facing_both: got %b expected 0", facing); end
    keycode_3 = 8'h00;
    step();
    tests++;
    if (facing !== 1'b1) begin fails++; $display("FAIL facing_right: got %b expected 1", facing); end
    keycode_4 = 8'h00; keycode_3 = LeftKey;
    step();
    keycode_3 = 8'h00;
    step();
    tests++;
    if (facing !== 1'b0) begin fails++; $display("FAIL facing_left_hold: got %b expected 0", facing); end
    // Left hitbox [90,110); victim [30,90) touches at 90.
    AttX = 10'd110; VicX = 10'd30;
    run_attack(act, hits, first);
    tests++;
    if (hits !== 0 || damage !== 10'd0) begin
      fails++; $display("FAIL edge_left_touch: hits=%0d dmg=%0d expected 0 0", hits, damage);
    end
    VicX = 10'd40;
    run_attack(act, hits, first);
    tests++;
    if (hits !== 8 || damage !== 10'd10) begin
      fails++; $display("FAIL left_connect: hits=%0d dmg=%0d expected 8 10", hits, damage);
    end
    AttX = 10'd100; VicX = 10'd170;
  endtask

  task automatic test_hold_key();
    int act, hits;
    do_reset();
    act = 0; hits = 0;
    keycode_2 = AttackKey;
    for (int k = 0; k < 100; k++) begin
      step();
      if (attack_active) act++;
      if (hit) hits++;
    end
    keycode_2 = 8'h00;
    step();
    tests++;
    if (act !== 7 || hits !== 8) begin
      fails++; $display("FAIL hold_key: act=%0d hits=%0d expected 7 8", act, hits);
    end
    tests++;
    if (damage !== 10'd10) begin fails++; $display("FAIL hold_key_damage: got %0d expected 10", damage); end
  endtask

  task automatic test_saturation();
    int act, hits, first;
    do_reset();
    for (int n = 0; n < 99; n++) run_attack(act, hits, first);
    tests++;
    if (damage !== 10'd990) begin fails++; $display("FAIL sat_preload: got %0d expected 990", damage); end
    run_attack(act, hits, first);
    tests++;
    if (damage !== 10'd999) begin fails++; $display("FAIL sat_damage: got %0d expected 999", damage); end
    tests++;
    if (launch_dist !== 13'd4092 || launch_dist[11:5] !== 7'd127) begin
      fails++; $display("FAIL sat_launch: got %0d expected 4092", launch_dist);
    end
    run_attack(act, hits, first);
    tests++;
    if (damage !== 10'd999 || hits !== 8) begin
      fails++; $display("FAIL sat_again: dmg=%0d hits=%0d expected 999 8", damage, hits);
    end
  endtask

  task automatic test_death();
    int act, hits, first;
    do_reset();
    for (int n = 0; n < 4; n++) run_attack(act, hits, first);
    keycode_1 = AttackKey;
    step();
    keycode_1 = 8'h00;
    for (int k = 1; k <= 5; k++) step();
    tests++;
    if (hit !== 1'b1 || damage !== 10'd50 || launch_dist !== 13'd296) begin
      fails++; $display("FAIL death_pre: hit=%b dmg=%0d launch=%0d expected 1 50 296",
                        hit, damage, launch_dist);
    end
    vic_death = 1'b1;
    step();
    vic_death = 1'b0;
    tests++;
    if (hit !== 1'b0 || damage !== 10'd0 || launch_dist !== 13'd0) begin
      fails++; $display("FAIL death_clear: hit=%b dmg=%0d launch=%0d expected 0 0 0",
                        hit, damage, launch_dist);
    end
    for (int k = 0; k < 21; k++) step();
    run_attack(act, hits, first);
    // Death asserted across every ACTIVE frame: no connect can occur.
    hits = 0;
    keycode_1 = AttackKey;
    step();
    keycode_1 = 8'h00;
    for (int k = 1; k <= 4; k++) step();
    vic_death = 1'b1;
    step();
    tests++;
    if (hit !== 1'b0 || damage !== 10'd0 || launch_dist !== 13'd0) begin
      fails++; $display("FAIL death_on_connect: hit=%b dmg=%0d launch=%0d expected 0 0 0",
                        hit, damage, launch_dist);
    end
    for (int k = 6; k <= 7; k++) begin
      step();
      if (hit) hits++;
    end
    vic_death = 1'b0;
    for (int k = 8; k <= 27; k++) begin
      step();
      if (hit) hits++;
    end
    tests++;
    if (hits !== 0 || damage !== 10'd0) begin
      fails++; $display("FAIL death_no_late_hit: hits=%0d dmg=%0d expected 0 0", hits, damage);
    end
  endtask

  task automatic test_reset_mid();
    int act;
    do_reset();
    keycode_1 = AttackKey;
    step();
    keycode_1 = 8'h00;
    for (int k = 1; k <= 6; k++) step();
    tests++;
    if (hit !== 1'b1 || attack_active !== 1'b1) begin
      fails++; $display("FAIL mid_pre: hit=%b act=%b expected 1 1", hit, attack_active);
    end
    Reset_n = 1'b0;
    keycode_2 = LeftKey;
    step();
    tests++;
    if ({hit, launch_dist, damage, attack_active, facing} !== {1'b0, 13'd0, 10'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL mid_reset: hit=%b launch=%0d dmg=%0d act=%b facing=%b, expected 0 0 0 0 1",
               hit, launch_dist, damage, attack_active, facing);
    end
    Reset_n = 1'b1;
    keycode_2 = 8'h00;
    act = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (attack_active || hit) act++;
    end
    tests++;
    if (act !== 0) begin fails++; $display("FAIL idle_no_key: busy frames=%0d expected 0", act); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset_n = 1'b0;
    test_reset();
    test_basic_connect();
    test_boundary();
    test_hold_key();
    test_saturation();
    test_death();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/attack_hit_ctrl.md
Name: attack_hit_ctrl

Overview:
- Attacker-side source of the hit / launch_dist interface consumed by each player movement block.
- Detects the attacking player's attack key, sequences the attack through windup, active and cooldown frames, and tests the attack hitbox against the victim sprite box.
- On a connect, accumulates victim damage percent, computes the knockback magnitude, and holds hit for a fixed number of frames.
- Two instances sit in the top level, one per attacker→victim direction, clocked by frame_clk.

Parameters:
ATTACK_KEY, 8'h2C, keycode that starts an attack
LEFT_KEY, 8'h50, keycode that sets facing left
RIGHT_KEY, 8'h4F, keycode that sets facing right
WINDUP_FRAMES, 4, frames spent in WINDUP
ACTIVE_FRAMES, 3, frames the hitbox is live
COOLDOWN_FRAMES, 20, frames spent in COOLDOWN
HIT_HOLD, 8, frames hit stays high after a connect
REACH, 20, hitbox width in pixels beyond the attacker edge
DMG_PER_HIT, 10, percent added per connect
DMG_MAX, 999, damage saturation value
KB_BASE, 96, base knockback
KB_SHIFT, 2, damage-to-knockback left shift

Ports:
frame_clk  in  1  frame clock; the only clock
Reset_n  in  1  synchronous, active-low reset
keycode_1..keycode_4  in  8 each  current USB keycodes
AttX, AttY, AttW, AttH  in  10 each  attacker sprite top-left corner and size
VicX, VicY, VicW, VicH  in  10 each  victim sprite top-left corner and size
vic_death  in  1  victim death_status
hit  out  1  knockback request to victim movement block
launch_dist  out  13  knockback magnitude; victim uses bits [11:5]
damage  out  10  victim damage percent, 0..DMG_MAX
attack_active  out  1  high in WINDUP and ACTIVE (for sprite animation)
facing  out  1  1 = facing right

Behaviour:
- Clock and reset: one clock, frame_clk. Reset_n is synchronous and active-low.
- Reset state (Reset_n=0 at a frame_clk edge): state=IDLE, hit=0, launch_dist=0, damage=0, attack_active=0, facing=1, all counters=0, key-edge register=0.
- Key decoding: a key is "pressed" if any keycode_n equals it.
- Facing: LEFT_KEY pressed → facing=0; RIGHT_KEY pressed → facing=1. If both are pressed, LEFT wins. Otherwise facing holds.
- Attack start: requires a rising edge of ATTACK_KEY pressed, registered one frame. Holding the key never re-triggers.
- FSM, state updates every frame_clk:
  - IDLE → WINDUP on an attack-key edge; frame counter loads 0.
  - WINDUP → ACTIVE when counter = WINDUP_FRAMES-1.
  - ACTIVE → COOLDOWN when counter = ACTIVE_FRAMES-1.
  - COOLDOWN → IDLE when counter = COOLDOWN_FRAMES-1.
  - Attack-key edges outside IDLE are ignored.
- Hitbox: use 11-bit unsigned arithmetic throughout.
  - X range, facing right: [AttX+AttW, AttX+AttW+REACH).
  - X range, facing left: [max(AttX-REACH,0), AttX).
  - Y range: [AttY, AttY+AttH).
  - Overlap: both axes intersect the victim box [VicX, VicX+VicW) × [VicY, VicY+VicH). Touching edges do not overlap.
- Connect: the first ACTIVE frame with overlap and vic_death=0.
  - At most one connect per attack; a "connected" flag is cleared on entry to WINDUP.
  - At the connect edge, update damage_new = min(damage+DMG_PER_HIT, DMG_MAX).
  - At the same edge, update launch_dist = min(KB_BASE + (damage_new << KB_SHIFT), 13'h0FFF), computed from damage_new. Bit 12 is always 0.
  - At the same edge, hit goes 1 and the hold counter loads HIT_HOLD.
- Hit hold:
  - hit stays high while the hold counter is nonzero; the counter decrements each frame.
  - hit drops after exactly HIT_HOLD frames high, independent of FSM state (it may extend into COOLDOWN or IDLE).
  - launch_dist holds its value until the next connect; it is not cleared when hit falls.
- vic_death=1 at an edge:
  - damage=0, hit=0, hold counter=0, launch_dist=0.
  - The FSM keeps running.
  - A simultaneous connect is suppressed; death wins.
- A second connect while hit is still held (new attack) reloads the hold counter and updates damage and launch_dist.
- Damage at DMG_MAX stays at DMG_MAX; the connect still asserts hit.
- Reset_n low mid-attack or mid-hold returns everything to the reset state on that edge.

Test Plan:
- Reset, then press ATTACK_KEY once with the victim overlapping (Att 100,230,60,60, facing right; Vic 170,230,60,60) → attack_active high for 7 frames. Connect on the 1st ACTIVE frame: damage=10, launch_dist=136, hit high 8 frames, then IDLE after 20 cooldown frames.
- Same stimulus but victim at VicX=180 (box edge exactly at AttX+AttW+REACH=180) → no hit, damage stays 0. With facing=0 and VicX=30 (touching at AttX-REACH) → no hit.
- Hold ATTACK_KEY for 100 frames → exactly one attack sequence and one connect.
- Preload 99 connects → damage=990; next connect → damage=999, launch_dist=4092 (bits[11:5]=127); further connect → damage stays 999, hit still asserts.
- Assert vic_death during hit hold at damage=50 → next frame hit=0, damage=0, launch_dist=0. vic_death on the connect frame → no damage increment.
- Drive Reset_n=0 during ACTIVE with hit high → next edge all outputs at reset values. Reset_n high with no key → stays IDLE.
